// File: rtl/ps2_jump_receiver.sv
// rtl/ps2_jump_receiver.sv - PS/2 keyboard frame receiver with jump-key make/break tracking
module ps2_jump_receiver #(
    parameter int         TIMEOUT_CYCLES = 200000,
    parameter logic [7:0] JUMP_CODE      = 8'h29
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       scancode_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       jump,
    output logic       jump_held
);

    localparam logic [17:0] TIMEOUT_VAL = 18'(TIMEOUT_CYCLES);
    localparam logic [7:0]  BREAK_CODE  = 8'hF0;
    localparam logic [7:0]  EXT_CODE    = 8'hE0;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  clk_sync;
    logic [1:0]  data_sync;
    logic        clk_prev;
    logic        fall;
    logic        bit_in;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        parity_bit;
    logic [17:0] wd_cnt;
    logic        timeout;
    logic        break_pending;
    logic        ext_pending;

    logic        frame_ok;
    logic [7:0]  scancode_n;
    logic        scancode_valid_n;
    logic        parity_err_n;
    logic        frame_err_n;
    logic        jump_n;
    logic        jump_held_n;
    logic        break_pending_n;
    logic        ext_pending_n;

    // Synchronizers idle high so reset never fabricates a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall    = clk_prev & ~clk_sync[1];
    assign bit_in  = data_sync[1];
    assign timeout = (state != IDLE) && !fall && (wd_cnt == TIMEOUT_VAL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fall && !bit_in) state_next = DATA;
            DATA:    if (fall && bit_cnt == 3'd7) state_next = PARITY;
            PARITY:  if (fall) state_next = STOP;
            STOP:    if (fall) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (timeout) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
            parity_bit <= 1'b0;
            wd_cnt     <= 18'd0;
        end else begin
            if (state == IDLE || fall || timeout) begin
                wd_cnt <= 18'd0;
            end else begin
                wd_cnt <= wd_cnt + 18'd1;
            end
            if (timeout) begin
                shift   <= 8'h00;
                bit_cnt <= 3'd0;
            end else if (fall) begin
                case (state)
                    IDLE: if (!bit_in) bit_cnt <= 3'd0;
                    DATA: begin
                        shift   <= {bit_in, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY:  parity_bit <= bit_in;
                    default: ;
                endcase
            end
        end
    end

    // Decode of the completed frame; results are registered below so every pulse lands one cycle after the stop edge.
    always_comb begin
        scancode_n       = scancode;
        scancode_valid_n = 1'b0;
        parity_err_n     = 1'b0;
        frame_err_n      = timeout;
        jump_n           = 1'b0;
        jump_held_n      = jump_held;
        break_pending_n  = break_pending;
        ext_pending_n    = ext_pending;
        frame_ok         = 1'b0;
        if (state == STOP && fall) begin
            if (!bit_in) begin
                frame_err_n = 1'b1;
            end else if ((^shift) ^ parity_bit) begin
                frame_ok = 1'b1;
            end else begin
                parity_err_n = 1'b1;
            end
        end
        if (frame_ok) begin
            scancode_n       = shift;
            scancode_valid_n = 1'b1;
            if (shift == BREAK_CODE) begin
                break_pending_n = 1'b1;
            end else if (shift == EXT_CODE) begin
                ext_pending_n = 1'b1;
            end else begin
                break_pending_n = 1'b0;
                ext_pending_n   = 1'b0;
                if (shift == JUMP_CODE && !ext_pending) begin
                    if (break_pending) begin
                        jump_held_n = 1'b0;
                    end else if (!jump_held) begin
                        jump_n      = 1'b1;
                        jump_held_n = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scancode       <= 8'h00;
            scancode_valid <= 1'b0;
            parity_err     <= 1'b0;
            frame_err      <= 1'b0;
            jump           <= 1'b0;
            jump_held      <= 1'b0;
            break_pending  <= 1'b0;
            ext_pending    <= 1'b0;
        end else begin
            scancode       <= scancode_n;
            scancode_valid <= scancode_valid_n;
            parity_err     <= parity_err_n;
            frame_err      <= frame_err_n;
            jump           <= jump_n;
            jump_held      <= jump_held_n;
            break_pending  <= break_pending_n;
            ext_pending    <= ext_pending_n;
        end
    end

endmodule

// File: tb/tb_ps2_jump_receiver.sv
// tb/tb_ps2_jump_receiver.sv - randomized self-checking bench for ps2_jump_receiver
module tb_ps2_jump_receiver;

    localparam int         TO   = 3000;
    localparam logic [7:0] JMP  = 8'h29;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scancode;
    logic       scancode_valid;
    logic       parity_err;
    logic       frame_err;
    logic       jump;
    logic       jump_held;

    ps2_jump_receiver #(.TIMEOUT_CYCLES(TO), .JUMP_CODE(JMP)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scancode(scancode), .scancode_valid(scancode_valid), .parity_err(parity_err),
        .frame_err(frame_err), .jump(jump), .jump_held(jump_held)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [7:0] sc;
        logic       jmp;
        logic       held;
    } ev_t;

    ev_t        exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         jump_count = 0;
    logic [7:0] m_sc = 8'h00;
    logic       m_brk = 1'b0;
    logic       m_ext = 1'b0;
    logic       m_held = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_sc = 8'h00; m_brk = 1'b0; m_ext = 1'b0; m_held = 1'b0;
        exp_q.delete();
    endtask

    // Reference behaviour of one complete frame, pushed as the expected pulse event.
    task automatic model_frame(input logic [7:0] code, input logic par, input logic stop);
        ev_t e;
        e.jmp = 1'b0;
        if (!stop) e.kind = 2;
        else if ((^code) ^ par) e.kind = 0;
        else e.kind = 1;
        if (e.kind == 0) begin
            m_sc = code;
            if (code == 8'hF0) m_brk = 1'b1;
            else if (code == 8'hE0) m_ext = 1'b1;
            else begin
                if (code == JMP && !m_ext) begin
                    if (m_brk) m_held = 1'b0;
                    else if (!m_held) begin e.jmp = 1'b1; m_held = 1'b1; end
                end
                m_brk = 1'b0; m_ext = 1'b0;
            end
        end
        e.sc = m_sc;
        e.held = m_held;
        exp_q.push_back(e);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits, input int hp);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_cyc(hp / 2);
            ps2_clk = 1'b0;
            wait_cyc(hp);
            ps2_clk = 1'b1;
            wait_cyc(hp / 2);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            wait_cyc(1);
            n++;
        end
        chk("drain_pending_events", exp_q.size(), 0);
        exp_q.delete();
        wait_cyc(5);
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic bad_stop, input int hp);
        logic par;
        logic stop;
        par  = (~^code) ^ bad_par;
        stop = ~bad_stop;
        model_frame(code, par, stop);
        send_bits({stop, par, code, 1'b0}, 11, hp);
        wait_drain();
    endtask

    always @(negedge clk) begin
        if (!reset && (scancode_valid || parity_err || frame_err || jump)) begin
            int k;
            ev_t e;
            if (jump) jump_count++;
            k = (scancode_valid && !parity_err && !frame_err) ? 0 :
                (!scancode_valid && parity_err && !frame_err && !jump) ? 1 :
                (!scancode_valid && !parity_err && frame_err && !jump) ? 2 : 3;
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {28'd0, scancode_valid, parity_err, frame_err, jump}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind", k, e.kind);
                chk("jump_pulse", {31'd0, jump}, {31'd0, e.jmp});
                chk("scancode", {24'd0, scancode}, {24'd0, e.sc});
                chk("jump_held", {31'd0, jump_held}, {31'd0, e.held});
            end
        end
    end

    initial begin
        int hp;
        int r;
        logic [7:0] code;
        int jc;

        wait_cyc(5);
        @(negedge clk);
        chk("reset_outputs", {24'd0, scancode, scancode_valid, parity_err, frame_err, jump, jump_held}, 32'd0);
        wait_cyc(1);
        reset = 1'b0;
        wait_cyc(10);
        chk("idle_after_reset", {24'd0, scancode, jump_held}, 32'd0);

        send_frame(8'h29, 1'b0, 1'b0, 30);
        chk("first_make_scancode", {24'd0, scancode}, 32'h29);
        chk("first_make_held", {31'd0, jump_held}, 32'd1);
        chk("first_make_jumps", jump_count, 1);

        send_frame(8'h29, 1'b0, 1'b0, 24);
        chk("typematic_no_jump", jump_count, 1);
        send_frame(8'hF0, 1'b0, 1'b0, 24);
        send_frame(8'h29, 1'b0, 1'b0, 24);
        chk("break_released", {31'd0, jump_held}, 32'd0);
        chk("break_no_jump", jump_count, 1);

        send_frame(8'h29, 1'b0, 1'b0, 20);
        send_frame(8'h29, 1'b1, 1'b0, 20);
        chk("parity_keeps_held", {31'd0, jump_held}, 32'd1);
        chk("parity_keeps_scancode", {24'd0, scancode}, 32'h29);
        send_frame(8'hF0, 1'b0, 1'b0, 20);
        send_frame(8'h29, 1'b0, 1'b0, 20);

        jc = jump_count;
        send_frame(8'hE0, 1'b0, 1'b0, 20);
        send_frame(8'h29, 1'b0, 1'b0, 20);
        chk("ext_no_jump", jump_count, jc);
        chk("ext_no_held", {31'd0, jump_held}, 32'd0);
        send_frame(8'h29, 1'b0, 1'b1, 20);
        chk("bad_stop_no_jump", jump_count, jc);

        model_frame(8'h00, 1'b0, 1'b0);
        send_bits({6'b0, 4'b1001, 1'b0}, 5, 20);
        wait_cyc(TO + 100);
        wait_drain();
        send_frame(8'h29, 1'b0, 1'b0, 20);
        chk("after_timeout_jump", jump_count, jc + 1);
        chk("after_timeout_held", {31'd0, jump_held}, 32'd1);

        send_bits({2'b01, 8'h29, 1'b0}, 5, 20);
        ps2_data = 1'b0;
        wait_cyc(10);
        ps2_clk = 1'b0;
        wait_cyc(2);
        reset = 1'b1;
        model_reset();
        wait_cyc(3);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(1);
        @(negedge clk);
        chk("midframe_reset_outputs", {24'd0, scancode, scancode_valid, parity_err, frame_err, jump, jump_held}, 32'd0);
        wait_cyc(20);
        jc = jump_count;
        send_frame(8'h29, 1'b0, 1'b0, 20);
        chk("post_reset_jump", jump_count, jc + 1);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 7);
            if (r < 3) code = 8'h29;
            else if (r == 3) code = 8'hF0;
            else if (r == 4) code = 8'hE0;
            else code = 8'($urandom);
            hp = $urandom_range(16, 40);
            send_frame(code, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, hp);
            wait_cyc($urandom_range(0, 30));
        end
        chk("final_scancode", {24'd0, scancode}, {24'd0, m_sc});
        chk("final_held", {31'd0, jump_held}, {31'd0, m_held});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_jump_receiver.md
PS2_JUMP_RECEIVER -- requirements
Module: ps2_jump_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 200000, cycles of clk allowed between PS/2 clock falling edges mid-frame (2 ms at 100 MHz).
REQ-002 SHALL have parameter JUMP_CODE, default 8'h29, make code that drives jump (space key).
REQ-003 SHALL have port clk  input  1  100 MHz system clock; the only clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ps2_clk  input  1  raw keyboard clock, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  raw keyboard data, asynchronous to clk.
REQ-007 SHALL have port scancode  output  8  last correctly received byte.
REQ-008 SHALL have port scancode_valid  output  1  one-cycle pulse; scancode is new.
REQ-009 SHALL have port parity_err  output  1  one-cycle pulse; frame dropped on parity error.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse; frame dropped on bad stop bit or timeout.
REQ-011 SHALL have port jump  output  1  one-cycle pulse on a fresh JUMP_CODE make.
REQ-012 SHALL have port jump_held  output  1  level; JUMP_CODE key currently down.

Function
REQ-013 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer before any use.
REQ-014 SHALL detect a falling edge when the previous synchronized ps2_clk is 1 and the current one is 0; data is sampled from synchronized ps2_data in that same cycle.
REQ-015 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: on an edge with data 0 (start bit), go to DATA and clear the bit counter; on an edge with data 1, stay in IDLE with no error.
REQ-017 DATA: shift in 8 bits LSB first, one per edge, using a 3-bit counter; after the 8th bit, go to PARITY.
REQ-018 PARITY: capture the bit on the edge and go to STOP; parity is good when the XOR of the 8 data bits and the parity bit equals 1 (odd parity).
REQ-019 STOP, on an edge:
- stop=1 and parity good: load scancode and pulse scancode_valid.
- stop=1 and parity bad: pulse parity_err only.
- stop=0: pulse frame_err only, whatever the parity.
- In every case: return to IDLE.
REQ-020 All pulse outputs SHALL be registered, asserted in the cycle after the STOP edge is detected, and high for exactly one cycle.
REQ-021 Watchdog: a 18-bit counter SHALL reset on every edge and in IDLE; if it reaches TIMEOUT_CYCLES outside IDLE, pulse frame_err next cycle, return to IDLE and discard partial data.
REQ-022 Prefix 8'hF0 SHALL set break_pending; prefix 8'hE0 SHALL set ext_pending.
REQ-023 Any other valid byte SHALL clear both pending flags in the same cycle it is decoded.
REQ-024 Prefix bytes SHALL still be reported on scancode and scancode_valid.
REQ-025 A valid JUMP_CODE byte with ext_pending=0 and break_pending=0 is a make:
- jump_held=0: pulse jump and set jump_held.
- jump_held=1 (typematic repeat): no jump pulse.
REQ-026 A valid JUMP_CODE byte with ext_pending=0 and break_pending=1 is a break: clear jump_held.
REQ-027 JUMP_CODE bytes with ext_pending=1 SHALL not affect jump or jump_held.
REQ-028 jump SHALL rise in the same cycle as the scancode_valid pulse for that byte.
REQ-029 Errored frames SHALL leave scancode, pending flags and jump_held unchanged.

Reset
REQ-030 While reset=1 on a clk edge, SHALL force:
- FSM to IDLE; bit counter, watchdog and shift register to 0;
- break_pending=0, ext_pending=0;
- scancode=8'h00; scancode_valid, parity_err, frame_err, jump, jump_held all 0;
- synchronizer flops to 1 (bus idle).
REQ-031 Reset asserted mid-frame SHALL abort the frame with no pulse.
REQ-032 After reset, the next frame SHALL decode normally from its start bit.

Verification
REQ-033 Valid frame 0x29 (start 0, data 1,0,0,1,0,1,0,0, parity 0, stop 1) at a 15 kHz PS/2 clock -> scancode=8'h29, scancode_valid=1 one cycle, jump=1 one cycle, jump_held=1.
REQ-034 Frames 0x29, 0x29 -> one jump pulse only; then frames F0 (parity 1), 29 -> two more scancode_valid pulses, jump_held=0, no jump.
REQ-035 0x29 sent with parity 1 -> parity_err=1 one cycle, no scancode_valid, scancode unchanged, jump_held unchanged.
REQ-036 Frame stopped after 4 data bits, then idle for 200000 cycles -> frame_err pulse, FSM back in IDLE; next frame 0x29 decodes correctly.
REQ-037 Frames E0, 29 -> scancode_valid twice, jump=0, jump_held=0; frame 0x29 with stop bit 0 -> frame_err only.
REQ-038 reset asserted at the 5th data edge of 0x29 -> no pulses; the following full 0x29 frame -> jump pulse.
